// File: rtl/snn_img_pkg.sv
// Shared constants, loader state encoding and RAM write request for the
// packed-image stream loader.
package snn_img_pkg;

  localparam int IM_WID       = 28;
  localparam int IM_HEI       = 28;
  localparam int M            = IM_WID * IM_HEI;
  localparam int PIX_W        = 8;
  localparam int WORD_W       = 32;
  localparam int PIX_PER_WORD = WORD_W / PIX_W;
  localparam int WORDS        = M / PIX_PER_WORD;
  localparam int PA_W         = $clog2(M);
  localparam int WA_W         = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, FIRE, BUSY} ld_state_e;

  typedef struct packed {
    logic              en;
    logic [WA_W-1:0]   addr;
    logic [WORD_W-1:0] data;
  } wr_req_t;

  // Pixels are packed MSB-first: slot 0 lives in the top byte of the word.
  function automatic logic [PIX_W-1:0] pick_pixel(input logic [WORD_W-1:0] w,
                                                   input logic [1:0]        j);
    return w[WORD_W-1-PIX_W*int'(j) -: PIX_W];
  endfunction

endpackage

// File: rtl/image_word_ram.sv
// WORDS x WORD_W simple dual-port RAM: one synchronous write, one synchronous
// read; a same-cycle read of the written word returns the old contents.
module image_word_ram
  import snn_img_pkg::*;
(
  input  logic              clk,
  input  wr_req_t           wr,
  input  logic [WA_W-1:0]   rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (wr.en) mem[wr.addr] <= wr.data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/image_stream_loader.sv
// Receives one packed image over the start_main/valid_image stream, buffers
// it, pulses start_core_img, serves registered pixel reads until core_done.
module image_stream_loader
  import snn_img_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_main,
  input  logic [WORD_W-1:0] image_in,
  input  logic              valid_image,
  input  logic              core_done,
  input  logic [PA_W-1:0]   rd_addr,
  output logic              ready,
  output logic              start_core_img,
  output logic [PIX_W-1:0]  rd_pixel,
  output logic [7:0]        word_count,
  output logic              err_proto
);

  ld_state_e state, nxt;
  logic      accept, clr_cnt, err_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt     = state;
    accept  = 1'b0;
    clr_cnt = 1'b0;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        // A word arriving with the start pulse is dropped silently; the host
        // sends word 0 on the following cycle.
        if (start_main) begin
          nxt     = LOAD;
          clr_cnt = 1'b1;
        end else if (valid_image) begin
          err_set = 1'b1;
        end
      end
      LOAD: begin
        if (valid_image) begin
          accept = 1'b1;
          if (word_count == 8'(WORDS-1)) nxt = FIRE;
        end
        if (start_main) err_set = 1'b1;
      end
      FIRE: begin
        nxt = BUSY;
        if (valid_image || start_main) err_set = 1'b1;
      end
      BUSY: begin
        if (valid_image || start_main) err_set = 1'b1;
        if (core_done) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         word_count <= '0;
    else if (clr_cnt) word_count <= '0;
    else if (accept)  word_count <= word_count + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_proto <= 1'b0;
    else if (err_set) err_proto <= 1'b1;
  end

  assign ready          = (state == IDLE);
  assign start_core_img = (state == FIRE);

  wr_req_t           wr;
  logic              rd_oor, oor_q;
  logic [1:0]        sel_q;
  logic [WA_W-1:0]   ram_raddr;
  logic [WORD_W-1:0] ram_q;

  assign wr        = '{en: accept, addr: WA_W'(word_count), data: image_in};
  assign rd_oor    = (rd_addr >= PA_W'(M));
  assign ram_raddr = rd_oor ? '0 : WA_W'(rd_addr[PA_W-1:2]);

  image_word_ram u_ram (
    .clk     (clk),
    .wr      (wr),
    .rd_addr (ram_raddr),
    .rd_data (ram_q)
  );

  // The RAM output has no reset, so the out-of-range flag resets high to
  // force rd_pixel to zero until the first real read completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oor_q <= 1'b1;
      sel_q <= '0;
    end else begin
      oor_q <= rd_oor;
      sel_q <= rd_addr[1:0];
    end
  end

  assign rd_pixel = oor_q ? '0 : pick_pixel(ram_q, sel_q);

endmodule

// File: doc/image_stream_loader.md
Name: image_stream_loader

Overview:
- Receiving end of the packed-image stream protocol driven by the host/bench.
- Protocol: start_main pulse, then M/4 32-bit words qualified by valid_image.
- Buffers one full image in word RAM, fires start_core_img for the pre-core/SNN core, and serves pixel reads to the core.
- Returns to ready once the core signals completion.

Parameters:
M, 784, pixels per image (IM_WID*IM_HEI); must be a multiple of 4
IM_WID, 28, image width in pixels
IM_HEI, 28, image height in pixels
PIX_W, 8, bits per pixel
WORD_W, 32, stream word width (4 pixels per word)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start_main  in  1  one-cycle pulse that opens an image transfer
image_in  in  32  packed pixel word
valid_image  in  1  image_in valid this cycle
core_done  in  1  one-cycle pulse from core: image processing finished
rd_addr  in  10  pixel index 0..M-1 requested by core
ready  out  1  high when idle and a start_main will be accepted
start_core_img  out  1  one-cycle pulse: image fully buffered
rd_pixel  out  8  pixel at rd_addr, registered
word_count  out  8  words accepted in the current transfer
err_proto  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, ready=1, start_core_img=0, rd_pixel=0, word_count=0, err_proto=0. RAM contents are not reset.
- Reset mid-LOAD: the partial image is abandoned, and the next transfer starts at word 0.
- States: IDLE, LOAD, FIRE, BUSY.
- IDLE:
  - start_main=1: go to LOAD next cycle, ready drops to 0 the same edge, word_count cleared to 0.
  - valid_image=1 without start_main: word ignored, err_proto set.
- Same-cycle start_main and valid_image in IDLE: start accepted; that word is ignored and is not flagged. The first word is expected on the cycle after start_main, matching the host timing.
- LOAD:
  - Each cycle with valid_image=1 writes image_in to RAM[word_count] and increments word_count.
  - Gaps (valid_image=0) are allowed, with no timeout.
  - start_main during LOAD is ignored and sets err_proto.
  - On acceptance of word M/4-1 (word_count 195 to 196), go to FIRE.
- FIRE: lasts exactly one cycle with start_core_img=1, then go to BUSY. Latency: start_core_img is high on the cycle after the edge that captured the last word.
- BUSY:
  - Core reads pixels.
  - valid_image or start_main in BUSY: ignored, err_proto set.
  - core_done=1: go to IDLE, ready=1 next cycle.
- core_done outside BUSY is ignored and not flagged.
- Pixel packing: pixel 4k+j is image_in[31-8j -: 8] of word k, MSB-first, so pixel 0 is in bits [31:24].
- Read: rd_pixel is valid one cycle after rd_addr and is readable in every state.
- rd_addr >= M returns 0.
- A read of a word being written in the same cycle returns the old data.
- word_count holds its value after LOAD until the next start_main.
- err_proto is cleared only by reset.

Decomposition:
- Shared package snn_img_pkg:
  - constants M, WORDS = M/4, PIX_PER_WORD = 4
  - address widths clog2(M) and clog2(WORDS)
  - loader state enum {IDLE, LOAD, FIRE, BUSY}
- Sub-module image_word_ram:
  - WORDS x 32 simple dual-port RAM
  - one synchronous write port, one synchronous read port
  - no reset
- Byte select: the loader registers rd_addr[1:0] alongside the RAM read to pick the byte.

Test Plan:
- Nominal load: pulse start_main, stream 196 words with word k = {4k+0,4k+1,4k+2,4k+3} mod 256, back-to-back → start_core_img single pulse on the cycle after word 195; rd_addr=5 gives rd_pixel=5 one cycle later; rd_addr=783 gives 15 (783 mod 256); ready=0 until core_done.
- Gapped stream: valid_image toggled 1,0,1,0 over the 196 words → identical RAM contents; start_core_img after the 196th accepted word only; word_count=196.
- Protocol errors:
  - valid_image in IDLE → err_proto=1, word_count stays 0.
  - start_main mid-LOAD → load continues uninterrupted.
- Reset mid-load: rst=0 after word 100 → ready=1, word_count=0, no start_core_img; a fresh full transfer then completes normally.
- Core handshake: core_done in IDLE ignored. In BUSY, core_done → ready=1 next cycle. A second image loaded afterwards overwrites the buffer, and readback shows the new values.
- Out of range read: rd_addr=800 → rd_pixel=0.
